// File: rtl/dbus_sram_responder.sv
// Word-organised SRAM responder for the core data port with programmable wait states.
// Optional random extra wait via DBUS_SRAM_RESP_LFSR_DELAY_EN.
module dbus_sram_responder #(
  parameter int                    ADDR_LEN   = 32,
  parameter int                    DATA_LEN   = 32,
  parameter logic [ADDR_LEN-1:0]   BASE_ADDR  = 32'h0f00_0000,
  parameter int                    DEPTH_LOG2 = 10,
  parameter int                    LATENCY    = 2
) (
  input  logic                clock,
  input  logic                rstn,
  input  logic [ADDR_LEN-1:0] in_paddr,
  input  logic                in_psel,
  input  logic                in_pwrite,
  input  logic [2:0]          in_psize,
  input  logic [DATA_LEN-1:0] in_pwdata,
  input  logic [3:0]          in_pwstrb,
  output logic [DATA_LEN-1:0] out_prdata,
  output logic                out_pvalid,
  output logic                out_perr
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [4:0] LAT5 = 5'(LATENCY);

  state_t              state;
  state_t              state_next;
  logic [4:0]          cnt;
  logic [4:0]          wait_cycles;
  logic                accept;
  logic                resp_entry;

  logic [ADDR_LEN-1:0] req_addr;
  logic                req_write;
  logic [2:0]          req_size;
  logic [DATA_LEN-1:0] req_wdata;
  logic [3:0]          req_strb;

  logic [ADDR_LEN-1:0] cur_addr;
  logic                cur_write;
  logic [2:0]          cur_size;
  logic [DATA_LEN-1:0] cur_wdata;
  logic [3:0]          cur_strb;
  logic [ADDR_LEN-1:0] cur_offset;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic                cur_err;

  logic [DATA_LEN-1:0] mem [2**DEPTH_LOG2];

  assign accept = (state == IDLE) && in_psel;

`ifdef DBUS_SRAM_RESP_LFSR_DELAY_EN
  logic [3:0] lfsr;

  // x^4+x^3+1 sequence, stepped once per accepted request
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      lfsr <= 4'b1001;
    end else if (accept) begin
      lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end
  end

  assign wait_cycles = LAT5 + {3'd0, lfsr[1:0]};
`else
  assign wait_cycles = LAT5;
`endif

  // With zero wait the request goes straight to RESP on the capture edge, so the
  // response path must look at the live inputs while still in IDLE.
  always_comb begin
    if (state == IDLE) begin
      cur_addr  = in_paddr;
      cur_write = in_pwrite;
      cur_size  = in_psize;
      cur_wdata = in_pwdata;
      cur_strb  = in_pwstrb;
    end else begin
      cur_addr  = req_addr;
      cur_write = req_write;
      cur_size  = req_size;
      cur_wdata = req_wdata;
      cur_strb  = req_strb;
    end
  end

  always_comb begin
    cur_offset = cur_addr - BASE_ADDR;
    cur_idx    = cur_offset[DEPTH_LOG2+1:2];
    cur_err    = 1'b0;
    if (cur_addr < BASE_ADDR)                          cur_err = 1'b1;
    if ((cur_offset >> (DEPTH_LOG2 + 2)) != '0)        cur_err = 1'b1;
    if (cur_size > 3'd2)                               cur_err = 1'b1;
    if ((cur_size == 3'd1) && cur_addr[0])             cur_err = 1'b1;
    if ((cur_size == 3'd2) && (cur_addr[1:0] != 2'b00)) cur_err = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_psel) state_next = (wait_cycles == 5'd0) ? RESP : WAIT;
      WAIT: if (cnt == 5'd1) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign resp_entry = rstn && (state_next == RESP) && (state != RESP);

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      req_addr   <= '0;
      req_write  <= 1'b0;
      req_size   <= 3'd0;
      req_wdata  <= '0;
      req_strb   <= 4'd0;
      out_pvalid <= 1'b0;
      out_perr   <= 1'b0;
      out_prdata <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt       <= wait_cycles;
        req_addr  <= in_paddr;
        req_write <= in_pwrite;
        req_size  <= in_psize;
        req_wdata <= in_pwdata;
        req_strb  <= in_pwstrb;
      end else if (state == WAIT) begin
        cnt <= cnt - 5'd1;
      end
      out_pvalid <= resp_entry;
      out_perr   <= resp_entry && cur_err;
      out_prdata <= (resp_entry && !cur_write && !cur_err) ? mem[cur_idx] : '0;
    end
  end

  // Storage is never reset; writes land only on the RESP-entry edge
  always_ff @(posedge clock) begin
    if (resp_entry && cur_write && !cur_err) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_strb[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: vector table, reset abandonment, back-to-back and random traffic.
module tb_dbus_sram_responder;

  localparam logic [31:0] BASE = 32'h0f00_0000;
  localparam logic [31:0] SPAN = 32'h0000_1000;
`ifdef DBUS_SRAM_RESP_LFSR_DELAY_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clock = 1'b0;
  logic        rstn;
  logic [31:0] paddr;
  logic        psel_a, psel_b;
  logic        pwrite;
  logic [2:0]  psize;
  logic [31:0] pwdata;
  logic [3:0]  pwstrb;
  logic [31:0] prdata_a, prdata_b;
  logic        pvalid_a, pvalid_b;
  logic        perr_a, perr_b;

  int checks = 0;
  int fails  = 0;
  int lfsr_pos = 0;
  logic [31:0] model_mem [int];
  logic [3:0]  lfsr_seq [15] = '{4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                                 4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110,
                                 4'b1100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
  vec_t vecs [16];

  always #5 clock = ~clock;

  dbus_sram_responder #(.LATENCY(LAT)) u_dut (
    .clock(clock), .rstn(rstn), .in_paddr(paddr), .in_psel(psel_a), .in_pwrite(pwrite),
    .in_psize(psize), .in_pwdata(pwdata), .in_pwstrb(pwstrb),
    .out_prdata(prdata_a), .out_pvalid(pvalid_a), .out_perr(perr_a)
  );

  dbus_sram_responder #(.LATENCY(0)) u_dut0 (
    .clock(clock), .rstn(rstn), .in_paddr(paddr), .in_psel(psel_b), .in_pwrite(pwrite),
    .in_psize(psize), .in_pwdata(pwdata), .in_pwstrb(pwstrb),
    .out_prdata(prdata_b), .out_pvalid(pvalid_b), .out_perr(perr_b)
  );

  function automatic logic model_err(input logic [31:0] addr, input logic [2:0] size);
    if (addr < BASE || addr >= BASE + SPAN) return 1'b1;
    if (size > 3'd2) return 1'b1;
    if (size == 3'd1 && addr[0]) return 1'b1;
    if (size == 3'd2 && addr[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_index(input logic [31:0] addr);
    return int'((addr - BASE) / 4);
  endfunction

  // Wait cycles the main DUT should insert for its next accepted request
  function automatic int next_gap();
    int g;
    g = LAT;
`ifdef DBUS_SRAM_RESP_LFSR_DELAY_EN
    g = g + int'(lfsr_seq[lfsr_pos % 15][1:0]);
`endif
    lfsr_pos++;
    return g;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    int idx;
    logic [31:0] w;
    idx = model_index(addr);
    w = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
    for (int i = 0; i < 4; i++) if (strb[i]) w[8*i +: 8] = wdata[8*i +: 8];
    model_mem[idx] = w;
  endtask

  // One request on DUT 'which' (0 = main, 1 = zero-latency), psel dropped after acceptance
  task automatic run_txn(input int which, input logic wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata, input logic [3:0] strb,
                         output logic [31:0] rdata, output logic err, output int gap);
    @(negedge clock);
    paddr = addr; pwrite = wr; psize = size; pwdata = wdata; pwstrb = strb;
    if (which == 0) psel_a = 1'b1; else psel_b = 1'b1;
    @(posedge clock);
    #1;
    psel_a = 1'b0; psel_b = 1'b0;
    gap = 0;
    while (!(which == 0 ? pvalid_a : pvalid_b) && gap < 40) begin
      check_output("idle_outputs", (which == 0) ? {prdata_a | {31'd0, perr_a}} : {prdata_b | {31'd0, perr_b}}, 32'h0);
      @(posedge clock);
      #1;
      gap++;
    end
    if (gap >= 40) check_output("pvalid_timeout", 32'(gap), 32'(-1));
    rdata = (which == 0) ? prdata_a : prdata_b;
    err   = (which == 0) ? perr_a : perr_b;
    @(posedge clock);
    #1;
    check_output("pvalid_pulse", {31'd0, (which == 0) ? pvalid_a : pvalid_b}, 32'h0);
  endtask

  task automatic apply_stimulus(input vec_t v, input string tag, input logic use_model);
    logic [31:0] rd, exp_rd;
    logic        er, exp_er;
    int          g, exp_g;
    exp_g = next_gap();
    if (use_model) begin
      exp_er = model_err(v.addr, v.size);
      exp_rd = (!v.wr && !exp_er) ? model_mem[model_index(v.addr)] : 32'h0;
    end else begin
      exp_er = v.exp_err;
      exp_rd = v.exp_rdata;
    end
    run_txn(0, v.wr, v.addr, v.size, v.wdata, v.strb, rd, er, g);
    check_output({tag, "_rdata"}, rd, exp_rd);
    check_output({tag, "_perr"}, {31'd0, er}, {31'd0, exp_er});
    check_output({tag, "_gap"}, 32'(g), 32'(exp_g));
    if (v.wr && !model_err(v.addr, v.size)) model_write(v.addr, v.wdata, v.strb);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          g;
    logic [31:0] b2b_data [4];
    vec_t        v;

    vecs[0]  = '{1'b1, 32'h0f00_0010, 3'd2, 32'hdead_beef, 4'hf, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0f00_0010, 3'd2, 32'h0,         4'h0, 32'hdead_beef, 1'b0};
    vecs[2]  = '{1'b1, 32'h0f00_0011, 3'd0, 32'h0000_5a00, 4'h2, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0f00_0010, 3'd2, 32'h0,         4'h0, 32'hdead_5aef, 1'b0};
    vecs[4]  = '{1'b0, 32'h0f00_1000, 3'd2, 32'h0,         4'h0, 32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b0, 32'h0f00_0002, 3'd2, 32'h0,         4'h0, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b0, 32'h0f00_0010, 3'd2, 32'h0,         4'h0, 32'hdead_5aef, 1'b0};
    vecs[7]  = '{1'b1, 32'h0f00_0020, 3'd2, 32'h1111_1111, 4'hf, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b0, 32'h0f00_0020, 3'd3, 32'h0,         4'h0, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 32'h0f00_0021, 3'd1, 32'h0,         4'h0, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b1, 32'h0eff_fffc, 3'd2, 32'haaaa_aaaa, 4'hf, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b0, 32'h0f00_0022, 3'd1, 32'h0,         4'h0, 32'h1111_1111, 1'b0};
    vecs[12] = '{1'b1, 32'h0f00_0ffc, 3'd2, 32'h1234_5678, 4'hf, 32'h0000_0000, 1'b0};
    vecs[13] = '{1'b0, 32'h0f00_0ffc, 3'd2, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
    vecs[14] = '{1'b1, 32'h0f00_0012, 3'd2, 32'hffff_ffff, 4'hf, 32'h0000_0000, 1'b1};
    vecs[15] = '{1'b0, 32'h0f00_0010, 3'd2, 32'h0,         4'h0, 32'hdead_5aef, 1'b0};

    rstn = 1'b0; psel_a = 1'b0; psel_b = 1'b0;
    paddr = '0; pwrite = 1'b0; psize = 3'd0; pwdata = '0; pwstrb = 4'h0;
    #12;
    check_output("reset_pvalid", {31'd0, pvalid_a}, 32'h0);
    check_output("reset_prdata", prdata_a, 32'h0);
    check_output("reset_perr", {31'd0, perr_a}, 32'h0);
    @(negedge clock);
    rstn = 1'b1;

    for (int i = 0; i < 16; i++) apply_stimulus(vecs[i], $sformatf("vec%0d", i), 1'b0);

    // Reset while the write to 0x20 is waiting: write and response are both abandoned
    @(negedge clock);
    paddr = 32'h0f00_0020; pwrite = 1'b1; psize = 3'd2; pwdata = 32'h2222_2222; pwstrb = 4'hf;
    psel_a = 1'b1;
    @(posedge clock);
    #1;
    psel_a = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check_output("abort_pvalid", {31'd0, pvalid_a}, 32'h0);
    check_output("abort_prdata", prdata_a, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      check_output("abort_hold_pvalid", {31'd0, pvalid_a}, 32'h0);
    end
    @(negedge clock);
    rstn = 1'b1;
    lfsr_pos = 0;
    v = '{1'b0, 32'h0f00_0020, 3'd2, 32'h0, 4'h0, 32'h1111_1111, 1'b0};
    apply_stimulus(v, "abort_readback", 1'b0);

`ifndef DBUS_SRAM_RESP_LFSR_DELAY_EN
    // Zero-latency responder: preload four words, then read them with psel held high
    for (int i = 0; i < 4; i++) begin
      b2b_data[i] = $urandom;
      run_txn(1, 1'b1, BASE + 32'h100 + 32'(4 * i), 3'd2, b2b_data[i], 4'hf, rd, er, g);
      check_output("b2b_wr_gap", 32'(g), 32'h0);
    end
    @(negedge clock);
    paddr = BASE + 32'h100; pwrite = 1'b0; psize = 3'd2; pwstrb = 4'h0;
    psel_b = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock);
      #1;
      check_output($sformatf("b2b_pvalid%0d", k), {31'd0, pvalid_b}, {31'd0, (k % 2) == 0});
      if ((k % 2) == 0) begin
        check_output($sformatf("b2b_rdata%0d", k / 2), prdata_b, b2b_data[k / 2]);
        if (k == 6) psel_b = 1'b0;
        else paddr = BASE + 32'h100 + 32'(4 * (k / 2 + 1));
      end
    end
`endif

    // Random traffic over a pre-written 16-word window plus occasional illegal addresses
    for (int i = 0; i < 16; i++) begin
      v = '{1'b1, BASE + 32'(4 * i), 3'd2, $urandom, 4'hf, 32'h0, 1'b0};
      apply_stimulus(v, $sformatf("fill%0d", i), 1'b1);
    end
    for (int i = 0; i < 40; i++) begin
      v.wr    = $urandom_range(0, 1) == 1;
      v.addr  = BASE + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) v.addr = ($urandom_range(0, 1) == 1) ? BASE + SPAN : BASE - 32'd4;
      v.size  = 3'($urandom_range(0, 3));
      v.wdata = $urandom;
      v.strb  = 4'($urandom_range(0, 15));
      apply_stimulus(v, $sformatf("rand%0d", i), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
